// File: rtl/bellek_asamasi_p.sv
// Memory stage: execute op -> L1D request with lane alignment, load extension.
// Optional BELLEK_HIZALAMA_HATA_EN: misaligned ops fault via gy_hata_o.
module bellek_asamasi_p #(
  parameter int VERI_BIT   = 32,
  parameter int PS_BIT     = 32,
  parameter int YAZMAC_BIT = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  istek_gecerli_i,
  output logic                  istek_hazir_o,
  input  logic                  istek_yaz_i,
  input  logic [1:0]            istek_boyut_i,
  input  logic                  istek_isaretsiz_i,
  input  logic [PS_BIT-1:0]     istek_adres_i,
  input  logic [VERI_BIT-1:0]   istek_veri_i,
  input  logic [YAZMAC_BIT-1:0] istek_rd_i,
  output logic                  l1v_istek_gecerli_o,
  input  logic                  l1v_istek_hazir_i,
  output logic [PS_BIT-1:0]     l1v_istek_adres_o,
  output logic                  l1v_istek_yaz_o,
  output logic [VERI_BIT-1:0]   l1v_istek_veri_o,
  output logic [VERI_BIT/8-1:0] l1v_istek_maske_o,
  input  logic                  l1v_veri_gecerli_i,
  output logic                  l1v_veri_hazir_o,
  input  logic [VERI_BIT-1:0]   l1v_veri_i,
  output logic                  gy_gecerli_o,
  output logic                  gy_yaz_o,
  output logic [YAZMAC_BIT-1:0] gy_rd_o,
  output logic [VERI_BIT-1:0]   gy_veri_o,
`ifdef BELLEK_HIZALAMA_HATA_EN
  output logic                  gy_hata_o,
`endif
  output logic                  cek_duraklat_o
);

  localparam int MB = VERI_BIT / 8;
  localparam int OB = $clog2(MB);
  localparam logic [1:0] BMAX =
    (VERI_BIT == 64) ? 2'd3 : 2'd2;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_t;

  durum_t                  durum;
  logic [1:0]              boyut_q;
  logic                    isaretsiz_q;
  logic [OB-1:0]           ofs_q;
  logic [YAZMAC_BIT-1:0]   rd_q;

  logic [1:0]              boyut_e;
  logic [OB-1:0]           alt_m;
  logic [OB-1:0]           ofs_h;
  logic [MB-1:0]           maske_d;
  logic [VERI_BIT-1:0]     veri_d;

  logic [VERI_BIT-1:0]     kay;
  logic [VERI_BIT-1:0]     yukle;
  logic                    isaret;
  int                      n;

  assign istek_hazir_o  = (durum == BOSTA) && !rst_i;
  assign cek_duraklat_o = istek_gecerli_i && !istek_hazir_o
                          && !rst_i;

  // Decode incoming op: clamp size, align offset, build lane mask/data
  always_comb begin
    boyut_e = (istek_boyut_i > BMAX) ? BMAX : istek_boyut_i;
    alt_m = '0;
    for (int i = 0; i < OB; i++)
      alt_m[i] = (i < int'(boyut_e));
    ofs_h = istek_adres_i[OB-1:0] & ~alt_m;
    maske_d = '0;
    for (int i = 0; i < MB; i++)
      maske_d[i] = (i >= int'(ofs_h)) &&
                   (i < int'(ofs_h) + (1 << boyut_e));
    veri_d = istek_veri_i << {ofs_h, 3'b000};
  end

`ifdef BELLEK_HIZALAMA_HATA_EN
  logic hizasiz;
  assign hizasiz = (istek_boyut_i > BMAX) ||
                   (|(istek_adres_i[OB-1:0] & alt_m));
`endif

  // Extract the addressed lane from the response and extend it
  always_comb begin
    kay = l1v_veri_i >> {ofs_q, 3'b000};
    n = 8 << boyut_q;
    case (boyut_q)
      2'd0:    isaret = kay[7];
      2'd1:    isaret = kay[15];
      2'd2:    isaret = kay[31];
      default: isaret = kay[VERI_BIT-1];
    endcase
    isaret = isaret && !isaretsiz_q;
    yukle = '0;
    for (int i = 0; i < VERI_BIT; i++)
      yukle[i] = (i < n) ? kay[i] : isaret;
  end

  // Stage FSM with registered cache request and write-back outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum               <= BOSTA;
      boyut_q             <= '0;
      isaretsiz_q         <= 1'b0;
      ofs_q               <= '0;
      rd_q                <= '0;
      l1v_istek_gecerli_o <= 1'b0;
      l1v_istek_adres_o   <= '0;
      l1v_istek_yaz_o     <= 1'b0;
      l1v_istek_veri_o    <= '0;
      l1v_istek_maske_o   <= '0;
      l1v_veri_hazir_o    <= 1'b0;
      gy_gecerli_o        <= 1'b0;
      gy_yaz_o            <= 1'b0;
      gy_rd_o             <= '0;
      gy_veri_o           <= '0;
`ifdef BELLEK_HIZALAMA_HATA_EN
      gy_hata_o           <= 1'b0;
`endif
    end else begin
      gy_gecerli_o <= 1'b0;
      gy_yaz_o     <= 1'b0;
`ifdef BELLEK_HIZALAMA_HATA_EN
      gy_hata_o    <= 1'b0;
`endif
      unique case (durum)
        BOSTA: begin
          if (istek_gecerli_i) begin
`ifdef BELLEK_HIZALAMA_HATA_EN
            if (hizasiz) begin
              gy_gecerli_o <= 1'b1;
              gy_hata_o    <= 1'b1;
              gy_rd_o      <= istek_rd_i;
              gy_veri_o    <= '0;
            end else begin
`endif
              l1v_istek_gecerli_o <= 1'b1;
              l1v_istek_adres_o   <=
                {istek_adres_i[PS_BIT-1:OB], {OB{1'b0}}};
              l1v_istek_yaz_o     <= istek_yaz_i;
              l1v_istek_veri_o    <= veri_d;
              l1v_istek_maske_o   <= maske_d;
              boyut_q             <= boyut_e;
              isaretsiz_q         <= istek_isaretsiz_i;
              ofs_q               <= ofs_h;
              rd_q                <= istek_rd_i;
              durum               <= ISTEK;
`ifdef BELLEK_HIZALAMA_HATA_EN
            end
`endif
          end
        end
        ISTEK: begin
          if (l1v_istek_hazir_i) begin
            l1v_istek_gecerli_o <= 1'b0;
            if (l1v_istek_yaz_o) begin
              gy_gecerli_o <= 1'b1;
              gy_rd_o      <= rd_q;
              gy_veri_o    <= '0;
              durum        <= BOSTA;
            end else begin
              l1v_veri_hazir_o <= 1'b1;
              durum            <= YANIT;
            end
          end
        end
        YANIT: begin
          if (l1v_veri_gecerli_i) begin
            l1v_veri_hazir_o <= 1'b0;
            gy_gecerli_o     <= 1'b1;
            gy_yaz_o         <= |rd_q;
            gy_rd_o          <= rd_q;
            gy_veri_o        <= yukle;
            durum            <= BOSTA;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule
